// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// Latency: none, wires only.
// Backpressure: memory stalls arrive on mem_ready; the FSM holds state until it is seen.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
    logic [3:0] state;

    // Controller side: sees instruction fields and status, drives controls.
    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op, state
    );

    // Datapath side: supplies instruction fields and status, consumes controls.
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath; optional addi support under MC_ADDI_EN.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles, plus one per mem_ready-low cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold (requests asserted) until mem_ready is high.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master ctl
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
`ifdef MC_ADDI_EN
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`else
        S_JUMP   = 4'd9
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic       pc_write, pc_write_cond;
    logic       iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       funct_ok;

    // Only these five R-type functions are implemented by the ALU.
    always_comb begin
        case (ctl.funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                                                funct_ok = 1'b0;
        endcase
    end

    // Next-state selection; an unsupported instruction returns to FETCH and flags illegal_op.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (ctl.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.opcode)
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (ctl.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (ctl.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (ctl.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // State and illegal-instruction pulse registers; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore decode of the control word from the current state.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_op        = ALU_AND;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = ctl.mem_ready;
                pc_write  = ctl.mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
`ifdef MC_ADDI_EN
            S_MEMADR, S_ADDIEX: begin
`else
            S_MEMADR: begin
`endif
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (ctl.funct)
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b101010: alu_op = ALU_SLT;
                    default:   alu_op = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MC_ADDI_EN
            S_ADDIWB: reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

    // Architectural write enables are blocked while reset is held.
    assign ctl.pc_en      = ~reset & (pc_write | (pc_write_cond & ctl.zero));
    assign ctl.mem_write  = ~reset & mem_write;
    assign ctl.ir_write   = ~reset & ir_write;
    assign ctl.reg_write  = ~reset & reg_write;
    assign ctl.iord       = iord;
    assign ctl.mem_read   = mem_read;
    assign ctl.reg_dst    = reg_dst;
    assign ctl.mem_to_reg = mem_to_reg;
    assign ctl.alu_src_a  = alu_src_a;
    assign ctl.alu_src_b  = alu_src_b;
    assign ctl.pc_source  = pc_source;
    assign ctl.alu_op     = alu_op;
    assign ctl.illegal_op = illegal_q;
    assign ctl.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: instruction-level model, per-cycle scoreboard.
// Stimulus builds whole-instruction cycle plans; a negedge monitor checks each cycle.
// Honors MC_ADDI_EN the same way the design does.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus ();
    multicycle_control dut (.clk(clk), .reset(reset), .ctl(bus));

    typedef struct packed {
        logic [20:0] exp;
        logic [20:0] mask;
    } sb_t;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       z;
        logic [5:0] op;
        logic [5:0] fn;
        sb_t        sb;
    } plan_t;

    localparam logic [20:0] RST_MASK = 21'h132000; // pc_en, mem_write, ir_write, reg_write

    sb_t   sbq[$];
    plan_t plan[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    pend_ill = 1'b0;
    logic [20:0] obs;
    sb_t   cur;

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b011;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a);
        if (op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h02) return 1'b1;
`ifdef MC_ADDI_EN
        if (op == 6'h08) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Expected control word for one cycle spent in a given state.
    function automatic logic [20:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z,
                                             input logic [5:0] fn, input logic ill);
        logic pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa;
        logic [1:0] sbsel, ps;
        logic [2:0] op;
        {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa} = '0;
        sbsel = 2'b00; ps = 2'b00; op = 3'b000;
        case (st)
            4'd0:        begin mrd = 1; sbsel = 2'b01; op = 3'b010; irw = mr; pc_en = mr; end
            4'd1:        begin sbsel = 2'b11; op = 3'b010; end
            4'd2, 4'd10: begin sa = 1; sbsel = 2'b10; op = 3'b010; end
            4'd3:        begin iord = 1; mrd = 1; end
            4'd4:        begin rw = 1; m2r = 1; end
            4'd5:        begin iord = 1; mwr = 1; end
            4'd6:        begin sa = 1; op = alu_of(fn); end
            4'd7:        begin rw = 1; rdst = 1; end
            4'd8:        begin sa = 1; op = 3'b011; pc_en = z; ps = 2'b01; end
            4'd9:        begin pc_en = 1; ps = 2'b10; end
            4'd11:       begin rw = 1; end
            default: ;
        endcase
        return {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sbsel, ps, op, ill, st};
    endfunction

    function automatic void add_cyc(input logic [3:0] st, input logic mr, input int zsel,
                                    input logic [5:0] op, input logic [5:0] fn, input logic ill);
        plan_t p;
        p.rst = 1'b0;
        p.mr  = mr;
        p.z   = (zsel == 2) ? 1'($urandom) : 1'(zsel);
        p.op  = op;
        p.fn  = fn;
        p.sb.exp  = exp_ctrl(st, mr, p.z, fn, ill);
        p.sb.mask = '1;
        plan.push_back(p);
    endfunction

    // One instruction: wf stall cycles in FETCH, wm stall cycles in its memory phase.
    function automatic void plan_instr(input logic [5:0] op, input logic [5:0] fn,
                                       input int wf, input int wm, input int zsel);
        for (int i = 0; i <= wf; i++)
            add_cyc(4'd0, (i == wf), zsel, op, fn, (i == 0) ? pend_ill : 1'b0);
        pend_ill = 1'b0;
        add_cyc(4'd1, 1'($urandom), zsel, op, fn, 1'b0);
        if (!is_legal(op, fn)) begin
            pend_ill = 1'b1;
        end else if (op == 6'h00) begin
            add_cyc(4'd6, 1'($urandom), zsel, op, fn, 1'b0);
            add_cyc(4'd7, 1'($urandom), zsel, op, fn, 1'b0);
        end else if (op == 6'h23 || op == 6'h2b) begin
            add_cyc(4'd2, 1'($urandom), zsel, op, fn, 1'b0);
            for (int i = 0; i <= wm; i++)
                add_cyc((op == 6'h23) ? 4'd3 : 4'd5, (i == wm), zsel, op, fn, 1'b0);
            if (op == 6'h23) add_cyc(4'd4, 1'($urandom), zsel, op, fn, 1'b0);
        end else if (op == 6'h04) begin
            add_cyc(4'd8, 1'($urandom), zsel, op, fn, 1'b0);
        end else if (op == 6'h02) begin
            add_cyc(4'd9, 1'($urandom), zsel, op, fn, 1'b0);
        end else begin
            add_cyc(4'd10, 1'($urandom), zsel, op, fn, 1'b0);
            add_cyc(4'd11, 1'($urandom), zsel, op, fn, 1'b0);
        end
    endfunction

    // Reset cycles: only the blocked write enables are predictable.
    function automatic void plan_reset(input int n, input logic [5:0] op);
        plan_t p;
        for (int i = 0; i < n; i++) begin
            p.rst = 1'b1; p.mr = 1'($urandom); p.z = 1'($urandom);
            p.op = op; p.fn = 6'($urandom);
            p.sb.exp = '0; p.sb.mask = RST_MASK;
            plan.push_back(p);
        end
        pend_ill = 1'b0;
    endfunction

    task automatic run_plan();
        plan_t p;
        while (plan.size() > 0) begin
            p = plan.pop_front();
            reset         = p.rst;
            bus.mem_ready = p.mr;
            bus.zero      = p.z;
            bus.opcode    = p.op;
            bus.funct     = p.fn;
            sbq.push_back(p.sb);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            cur = sbq.pop_front();
            obs = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                   bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                   bus.alu_op, bus.illegal_op, bus.state};
            n_tests++;
            if (((obs ^ cur.exp) & cur.mask) != 21'd0) begin
                n_fail++;
                $display("FAIL ctrl cycle %0d: got %b required %b (mask %b)",
                         cyc, obs, cur.exp, cur.mask);
            end
        end
        cyc++;
    end

    logic [5:0] rop, rfn;
    int         sel, cut, base;

    initial begin
        bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        // Directed cases
        plan_reset(2, 6'h00);          run_plan();
        plan_instr(6'h00, 6'h2a, 0, 0, 2); run_plan();
        plan_instr(6'h23, 6'h00, 0, 2, 2); run_plan();
        plan_instr(6'h04, 6'h00, 0, 0, 1); run_plan();
        plan_instr(6'h04, 6'h00, 0, 0, 0); run_plan();
        plan_instr(6'h3f, 6'h20, 0, 0, 2); run_plan();
        plan_instr(6'h00, 6'h00, 1, 0, 2); run_plan();
        plan_instr(6'h08, 6'h11, 0, 0, 2); run_plan();
        plan_instr(6'h2b, 6'h00, 2, 3, 2); run_plan();
        plan_instr(6'h02, 6'h00, 0, 0, 2); run_plan();
        // Abort a store mid-wait: no write may leak through the reset cycle.
        plan_instr(6'h2b, 6'h00, 0, 4, 2);
        while (plan.size() > 5) void'(plan.pop_back());
        plan_reset(1, 6'h2b);              run_plan();
        plan_instr(6'h00, 6'h20, 0, 0, 2); run_plan();

        // Randomized instruction stream
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 8);
            case (sel)
                0, 1:    rop = 6'h00;
                2:       rop = 6'h23;
                3:       rop = 6'h2b;
                4:       rop = 6'h04;
                5:       rop = 6'h02;
                6:       rop = 6'h08;
                default: rop = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rfn = 6'h20;
                1: rfn = 6'h22;
                2: rfn = 6'h24;
                3: rfn = 6'h25;
                4: rfn = 6'h2a;
                default: rfn = 6'($urandom);
            endcase
            base = plan.size();
            plan_instr(rop, rfn, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                       $urandom_range(0, 3), 2);
            if ($urandom_range(0, 15) == 0) begin
                cut = $urandom_range(1, plan.size() - base);
                while (plan.size() > base + cut) void'(plan.pop_back());
                plan_reset($urandom_range(1, 2), rop);
            end
            run_plan();
        end

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select. It produces the 3-bit `ALUOp` consumed by `ALU_Control`, using that block's encoding: AND=000, OR=001, ADD=010, SUB=011, SLT=100. Control outputs are Moore-style, decoded from the state register, except the handshake-qualified enables.

## Interface
- No parameters.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  instr[31:26] from the instruction register; stable from DECODE onward.
- `funct`  in  6  instr[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completion for the current access.
- `pc_en`  out  1  PC load: `pc_write | (pc_write_cond & zero)`.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction register load.
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = rs.
- `alu_src_b`  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `pc_source`  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_op`  out  3  ALU operation, sent to `ALU_Control`.
- `illegal_op`  out  1  registered one-cycle pulse for an unsupported instruction.
- `state`  out  4  current state, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `alu_src_b`=01, `alu_op`=ADD. `ir_write` and `pc_write` both equal `mem_ready`. Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `alu_src_b`=11, `alu_op`=ADD (branch target).
  - Next state by opcode: 000000 → EXEC; 100011 (lw) or 101011 (sw) → MEMADR; 000100 (beq) → BRANCH; 000010 (j) → JUMP; 001000 (addi) → ADDIEX.
  - An R-type funct outside {100000, 100010, 100100, 100101, 101010} is illegal.
  - Any other opcode, or an illegal funct: go to FETCH and set `illegal_op`=1 for the next cycle only.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=ADD. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `iord`=1, `mem_read`=1. Wait on `mem_ready`, then go to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Go to FETCH.
- MEMWR: `iord`=1, `mem_write`=1. Wait on `mem_ready`, then go to FETCH. `mem_write` stays high through all wait cycles.
- EXEC: `alu_src_a`=1, `alu_src_b`=00. `alu_op` by funct: 100000 → ADD, 100010 → SUB, 100100 → AND, 100101 → OR, 101010 → SLT. Go to ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1. Go to FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=SUB, `pc_write_cond`=1, `pc_source`=01. Go to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Go to FETCH.
- ADDIEX: as MEMADR. Go to ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Go to FETCH.
- Reset:
  - While `reset`=1, `pc_en`, `mem_write`, `ir_write` and `reg_write` are forced to 0 combinationally.
  - Reset loads state=FETCH and `illegal_op`=0.
  - After reset, all outputs take their FETCH values.
  - Reset asserted mid-instruction aborts it; no write occurs in the reset cycle.

## Timing
- Latency with `mem_ready` high on first request:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds one cycle.
- All outputs are valid within the cycle, derived from the registered state plus `mem_ready`, `zero` and `funct`. No output feeds back combinationally into any input.
- `illegal_op` is high during exactly the first FETCH cycle after the offending DECODE.

## Configuration
- `MC_ADDI_EN` defined: opcode 001000 is decoded and runs ADDIEX → ADDIWB.
- `MC_ADDI_EN` undefined:
  - States 10 and 11 are absent.
  - Opcode 001000 is illegal: DECODE → FETCH with an `illegal_op` pulse.

## Test plan
- Reset held 2 cycles, then released with `mem_ready`=1 → `state`=0, `mem_read`=1, `alu_op`=010, `pc_en`=0 during reset and 1 on the first cycle after release.
- R-type with funct 101010, `mem_ready`=1 → states 0,1,6,7,0. `alu_op`=100 in EXEC. `reg_write`=1 and `reg_dst`=1 only in ALUWB.
- lw with `mem_ready` low for 2 cycles in MEMRD → MEMRD lasts 3 cycles, `iord`=1 throughout, then MEMWB with `mem_to_reg`=1.
- beq with `zero`=1, then beq with `zero`=0 → `pc_en`=1 in BRANCH for the first, 0 for the second. `alu_op`=011 in both.
- Opcode 111111, then R-type funct 000000 → DECODE → FETCH each time, `illegal_op` high for exactly 1 cycle each, no `reg_write`.
- addi with and without `MC_ADDI_EN` → defined: states 1,10,11 with `reg_write` in ADDIWB. Undefined: `illegal_op` pulse and return to FETCH.
